// File: rtl/unified_cache_mem_ctrl_pkg.sv
// Shared packet layout, block geometry and controller state type for the
// unified-cache backing memory controller.
package unified_cache_mem_ctrl_pkg;

    localparam int UNIFIED_CACHE_BLOCK_SIZE_IN_BITS       = 128;
    localparam int UNIFIED_CACHE_BLOCK_OFFSET_LEN_IN_BITS = 4;
    localparam int UNIFIED_CACHE_BYTE_MASK_LEN            = UNIFIED_CACHE_BLOCK_SIZE_IN_BITS / 8;
    localparam int CPU_ADDR_LEN_IN_BITS                   = 32;

    // Packet layout, LSB first: data | addr | type | byte mask | port | valid | is_write | cacheable
    localparam int DATA_POS_LO      = 0;
    localparam int DATA_POS_HI      = DATA_POS_LO + UNIFIED_CACHE_BLOCK_SIZE_IN_BITS - 1;
    localparam int ADDR_POS_LO      = DATA_POS_HI + 1;
    localparam int ADDR_POS_HI      = ADDR_POS_LO + CPU_ADDR_LEN_IN_BITS - 1;
    localparam int TYPE_POS_LO      = ADDR_POS_HI + 1;
    localparam int TYPE_POS_HI      = TYPE_POS_LO + 1;
    localparam int BYTE_MASK_POS_LO = TYPE_POS_HI + 1;
    localparam int BYTE_MASK_POS_HI = BYTE_MASK_POS_LO + UNIFIED_CACHE_BYTE_MASK_LEN - 1;
    localparam int PORT_NUM_POS_LO  = BYTE_MASK_POS_HI + 1;
    localparam int PORT_NUM_POS_HI  = PORT_NUM_POS_LO + 1;
    localparam int VALID_POS        = PORT_NUM_POS_HI + 1;
    localparam int IS_WRITE_POS     = VALID_POS + 1;
    localparam int CACHEABLE_POS    = IS_WRITE_POS + 1;
    localparam int UC_PACKET_WIDTH_IN_BITS = CACHEABLE_POS + 1;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        ACCESS,
        RESP
    } mem_ctrl_state_t;

    function automatic logic [UNIFIED_CACHE_BLOCK_SIZE_IN_BITS-1:0] expand_byte_mask(
        input logic [UNIFIED_CACHE_BYTE_MASK_LEN-1:0] mask
    );
        logic [UNIFIED_CACHE_BLOCK_SIZE_IN_BITS-1:0] bits;
        bits = '0;
        for (int unsigned i = 0; i < UNIFIED_CACHE_BYTE_MASK_LEN; i++) begin
            bits[i*8 +: 8] = {8{mask[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/unified_cache_mem_ctrl_packet_concat.sv
// Assembles a memory-to-cache packet from its individual fields.
module packet_concat
    import unified_cache_mem_ctrl_pkg::*;
#(
    parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = UC_PACKET_WIDTH_IN_BITS
) (
    input  logic [CPU_ADDR_LEN_IN_BITS-1:0]               addr_in,
    input  logic [UNIFIED_CACHE_BLOCK_SIZE_IN_BITS-1:0]   data_in,
    input  logic [1:0]                                    type_in,
    input  logic [UNIFIED_CACHE_BYTE_MASK_LEN-1:0]        byte_mask_in,
    input  logic [1:0]                                    port_num_in,
    input  logic                                          valid_in,
    input  logic                                          is_write_in,
    input  logic                                          cacheable_in,
    output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] packet_out
);

    always_comb begin
        packet_out = '0;
        packet_out[DATA_POS_HI:DATA_POS_LO]           = data_in;
        packet_out[ADDR_POS_HI:ADDR_POS_LO]           = addr_in;
        packet_out[TYPE_POS_HI:TYPE_POS_LO]           = type_in;
        packet_out[BYTE_MASK_POS_HI:BYTE_MASK_POS_LO] = byte_mask_in;
        packet_out[PORT_NUM_POS_HI:PORT_NUM_POS_LO]   = port_num_in;
        packet_out[VALID_POS]                         = valid_in;
        packet_out[IS_WRITE_POS]                      = is_write_in;
        packet_out[CACHEABLE_POS]                     = cacheable_in;
    end

endmodule

// File: rtl/unified_cache_mem_ctrl.sv
// Backing memory for the unified cache: accepts one packet at a time, waits
// MEM_DELAY cycles, reads or read-modify-writes one block, then returns a packet.
module unified_cache_mem_ctrl
    import unified_cache_mem_ctrl_pkg::*;
#(
    parameter int MEM_DELAY                          = 10,
    parameter int MEM_DEPTH_IN_BLOCKS                = 65536,
    parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = UC_PACKET_WIDTH_IN_BITS
) (
    input  logic                                          clk_in,
    input  logic                                          reset_in,
    input  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] request_packet_in,
    output logic                                          request_packet_ack_out,
    output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] return_packet_out,
    input  logic                                          return_packet_ack_in,
    output logic                                          busy_out
);

    localparam int IDX_W = $clog2(MEM_DEPTH_IN_BLOCKS);
    localparam int CNT_W = (MEM_DELAY > 1) ? $clog2(MEM_DELAY) : 1;
    localparam int BLK_W = UNIFIED_CACHE_BLOCK_SIZE_IN_BITS;

    mem_ctrl_state_t state, state_next;

    logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] req_q;
    logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] resp_packet;
    logic [CNT_W-1:0] delay_cnt;
    logic [1:0]       access_step;
    logic [BLK_W-1:0] mem [MEM_DEPTH_IN_BLOCKS];
    logic [BLK_W-1:0] rd_data, mask_bits, merged_data, resp_data;
    logic [IDX_W-1:0] block_idx;
    logic req_valid, req_live, req_is_write, delay_done, access_done, mem_re, mem_we;

    assign req_valid    = request_packet_in[VALID_POS];
    assign req_live     = req_q[VALID_POS];
    assign req_is_write = req_q[IS_WRITE_POS];
    assign block_idx    = req_q[ADDR_POS_LO + UNIFIED_CACHE_BLOCK_OFFSET_LEN_IN_BITS +: IDX_W];
    assign delay_done   = (delay_cnt == CNT_W'(MEM_DELAY - 1));

    // ACCESS step 0 reads; step 1 ends a read or writes back a merge; step 2 ends a write
    assign access_done = ((access_step == 2'd1) && !req_is_write) || (access_step == 2'd2);
    assign mem_re      = (state == ACCESS) && (access_step == 2'd0) && req_live;
    assign mem_we      = (state == ACCESS) && (access_step == 2'd1) && req_live && req_is_write
                         && !reset_in;

    assign mask_bits   = expand_byte_mask(req_q[BYTE_MASK_POS_HI:BYTE_MASK_POS_LO]);
    assign merged_data = (rd_data & ~mask_bits) | (req_q[DATA_POS_HI:DATA_POS_LO] & mask_bits);
    assign resp_data   = req_is_write ? merged_data : rd_data;

    always_ff @(posedge clk_in) begin
        if (mem_we) mem[block_idx] <= merged_data;
        if (mem_re) rd_data <= mem[block_idx];
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = (MEM_DELAY == 0) ? ACCESS : DELAY;
            DELAY:   if (delay_done) state_next = ACCESS;
            ACCESS:  if (access_done) state_next = RESP;
            RESP:    if (return_packet_ack_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_out = (state != IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            request_packet_ack_out <= 1'b0;
            return_packet_out      <= '0;
            req_q                  <= '0;
            delay_cnt              <= '0;
            access_step            <= '0;
        end else begin
            request_packet_ack_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q                  <= request_packet_in;
                        request_packet_ack_out <= 1'b1;
                    end
                end
                DELAY: delay_cnt <= delay_done ? '0 : delay_cnt + 1'b1;
                ACCESS: begin
                    if (access_done) begin
                        access_step       <= '0;
                        return_packet_out <= resp_packet;
                    end else begin
                        access_step <= access_step + 2'd1;
                    end
                end
                RESP: if (return_packet_ack_in) return_packet_out <= '0;
                default: ;
            endcase
        end
    end

    packet_concat #(
        .UNIFIED_CACHE_PACKET_WIDTH_IN_BITS(UNIFIED_CACHE_PACKET_WIDTH_IN_BITS)
    ) u_packet_concat (
        .addr_in      (req_q[ADDR_POS_HI:ADDR_POS_LO]),
        .data_in      (resp_data),
        .type_in      (req_q[TYPE_POS_HI:TYPE_POS_LO]),
        .byte_mask_in (req_q[BYTE_MASK_POS_HI:BYTE_MASK_POS_LO]),
        .port_num_in  (req_q[PORT_NUM_POS_HI:PORT_NUM_POS_LO]),
        .valid_in     (1'b1),
        .is_write_in  (req_is_write),
        .cacheable_in (req_q[CACHEABLE_POS]),
        .packet_out   (resp_packet)
    );

endmodule

// File: tb/tb_unified_cache_mem_ctrl.sv
// Directed bench for unified_cache_mem_ctrl: a transaction-level model (latency
// rules plus a block store) is compared with two DUT builds every cycle.
module tb_unified_cache_mem_ctrl;
    import unified_cache_mem_ctrl_pkg::*;

    localparam int PW = UC_PACKET_WIDTH_IN_BITS;
    localparam int BW = UNIFIED_CACHE_BLOCK_SIZE_IN_BITS;
    localparam int MW = UNIFIED_CACHE_BYTE_MASK_LEN;
    localparam int A_DELAY = 10;
    localparam int A_DEPTH = 65536;
    localparam int B_DELAY = 0;
    localparam int B_DEPTH = 16;

    localparam logic [BW-1:0] PAT_P  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [BW-1:0] PAT_Q  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [BW-1:0] PAT_Z  = 128'h1357_9BDF_2468_ACE0_1357_9BDF_2468_ACE0;
    localparam logic [BW-1:0] PAT_W  = 128'hCAFE_F00D_0BAD_BEEF_0011_2233_4455_6677;
    localparam logic [BW-1:0] PAT_R  = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
    localparam logic [BW-1:0] PAT_X  = {16{8'h5A}};
    localparam logic [BW-1:0] ALL_AA = {16{8'hAA}};
    localparam logic [BW-1:0] ALL_55 = {16{8'h55}};
    localparam logic [BW-1:0] MERGED = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_5555_5555;

    logic clk = 1'b0;
    logic rst;
    logic [PW-1:0] req [2];
    logic          ack_in [2];
    logic          ack_out [2];
    logic [PW-1:0] ret [2];
    logic          busy [2];

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned cyc = 0;
    bit checking = 1'b0;

    initial forever #5 clk = ~clk;

    unified_cache_mem_ctrl #(.MEM_DELAY(A_DELAY), .MEM_DEPTH_IN_BLOCKS(A_DEPTH)) dut_a (
        .clk_in(clk), .reset_in(rst), .request_packet_in(req[0]),
        .request_packet_ack_out(ack_out[0]), .return_packet_out(ret[0]),
        .return_packet_ack_in(ack_in[0]), .busy_out(busy[0])
    );

    unified_cache_mem_ctrl #(.MEM_DELAY(B_DELAY), .MEM_DEPTH_IN_BLOCKS(B_DEPTH)) dut_b (
        .clk_in(clk), .reset_in(rst), .request_packet_in(req[1]),
        .request_packet_ack_out(ack_out[1]), .return_packet_out(ret[1]),
        .return_packet_ack_in(ack_in[1]), .busy_out(busy[1])
    );

    function automatic int dly(input int k);
        return (k == 0) ? A_DELAY : B_DELAY;
    endfunction

    function automatic int depth(input int k);
        return (k == 0) ? A_DEPTH : B_DEPTH;
    endfunction

    function automatic logic [PW-1:0] mk_pkt(input logic wr, input logic [31:0] addr,
                                             input logic [BW-1:0] data, input logic [MW-1:0] mask,
                                             input logic [1:0] port, input logic cach,
                                             input logic [1:0] typ);
        logic [PW-1:0] p;
        p = '0;
        p[DATA_POS_HI:DATA_POS_LO]           = data;
        p[ADDR_POS_HI:ADDR_POS_LO]           = addr;
        p[TYPE_POS_HI:TYPE_POS_LO]           = typ;
        p[BYTE_MASK_POS_HI:BYTE_MASK_POS_LO] = mask;
        p[PORT_NUM_POS_HI:PORT_NUM_POS_LO]   = port;
        p[VALID_POS]                         = 1'b1;
        p[IS_WRITE_POS]                      = wr;
        p[CACHEABLE_POS]                     = cach;
        return p;
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each accepted request becomes busy, acks for one cycle, shows its
    // response after the fixed latency, and is released by a sampled ack.
    logic [BW-1:0] mm [longint];
    logic          m_busy [2] = '{1'b0, 1'b0};
    logic          m_ack [2]  = '{1'b0, 1'b0};
    logic          m_shown [2] = '{1'b0, 1'b0};
    logic          m_wr [2];
    logic [PW-1:0] m_ret [2] = '{'0, '0};
    logic [PW-1:0] m_pkt [2];
    logic [BW-1:0] m_wdata [2];
    longint        m_key [2];
    int unsigned   m_ret_at [2];
    int unsigned   m_commit_at [2];

    task automatic model_accept(input int k);
        logic [PW-1:0] p;
        logic [31:0]   addr;
        logic [BW-1:0] blk;
        longint        idx;
        p    = req[k];
        addr = p[ADDR_POS_HI:ADDR_POS_LO];
        idx  = longint'(addr >> UNIFIED_CACHE_BLOCK_OFFSET_LEN_IN_BITS) % longint'(depth(k));
        m_key[k] = (longint'(k) << 32) | idx;
        blk = mm.exists(m_key[k]) ? mm[m_key[k]] : '0;
        if (p[IS_WRITE_POS]) begin
            for (int b = 0; b < MW; b++) begin
                if (p[BYTE_MASK_POS_LO + b]) blk[b*8 +: 8] = p[DATA_POS_LO + b*8 +: 8];
            end
        end
        m_wr[k]    = p[IS_WRITE_POS];
        m_wdata[k] = blk;
        m_pkt[k]   = p;
        m_pkt[k][DATA_POS_HI:DATA_POS_LO] = blk;
        m_ret_at[k]    = cyc + $unsigned(dly(k) + (p[IS_WRITE_POS] ? 3 : 2));
        m_commit_at[k] = m_ret_at[k] - 1;
        m_busy[k]  = 1'b1;
        m_ack[k]   = 1'b1;
        m_shown[k] = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    m_busy[k] = 1'b0; m_ack[k] = 1'b0; m_shown[k] = 1'b0; m_ret[k] = '0;
                end else begin
                    m_ack[k] = 1'b0;
                    if (!m_busy[k]) begin
                        if (req[k][VALID_POS]) model_accept(k);
                    end else if (m_shown[k]) begin
                        if (ack_in[k]) begin
                            m_ret[k] = '0; m_shown[k] = 1'b0; m_busy[k] = 1'b0;
                        end
                    end else begin
                        if (m_wr[k] && cyc == m_commit_at[k]) mm[m_key[k]] = m_wdata[k];
                        if (cyc == m_ret_at[k]) begin
                            m_ret[k] = m_pkt[k]; m_shown[k] = 1'b1;
                        end
                    end
                end
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("dut%0d_ack", k), PW'(ack_out[k]), PW'(m_ack[k]));
                    chk($sformatf("dut%0d_busy", k), PW'(busy[k]), PW'(m_busy[k]));
                    chk($sformatf("dut%0d_ret", k), ret[k], m_ret[k]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input logic [PW-1:0] p, output int unsigned acc);
        bit ok;
        ok = 1'b0;
        req[k] = p;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ack_out[k]) begin
                ok = 1'b1;
                break;
            end
        end
        acc = cyc;
        req[k] = '0;
        chk("accept_wait", PW'(ok), PW'(1));
    endtask

    task automatic complete(input int k, input int hold, input int unsigned acc,
                            output int lat, output logic [PW-1:0] got);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (ret[k][VALID_POS]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("return_wait", PW'(ok), PW'(1));
        lat = int'(cyc - acc);
        got = ret[k];
        repeat (hold) tick();
        ack_in[k] = 1'b1;
        tick();
        ack_in[k] = 1'b0;
    endtask

    task automatic txn(input int k, input logic [PW-1:0] p, output int lat, output logic [PW-1:0] got);
        int unsigned acc;
        issue(k, p, acc);
        complete(k, 0, acc, lat, got);
    endtask

    initial begin
        int            lat;
        int unsigned   acc;
        logic [PW-1:0] got, exp_bp;

        rst = 1'b1;
        req[0] = '0; req[1] = '0;
        ack_in[0] = 1'b0; ack_in[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checking = 1'b1;
        chk("reset_ack", PW'(ack_out[0]), '0);
        chk("reset_ret", ret[0], '0);
        chk("reset_busy", PW'(busy[0]), '0);
        rst = 1'b0;

        // Read after reset of a preloaded block
        txn(0, mk_pkt(1'b1, 32'h400, PAT_P, 16'hFFFF, 2'd0, 1'b0, 2'd0), lat, got);
        rst = 1'b1; tick(); rst = 1'b0;
        txn(0, mk_pkt(1'b0, 32'h400, '0, 16'h0000, 2'd1, 1'b0, 2'd0), lat, got);
        chk("read_latency", PW'(lat), PW'(12));
        chk("read_data", PW'(got[DATA_POS_HI:DATA_POS_LO]), PW'(PAT_P));
        chk("read_port", PW'(got[PORT_NUM_POS_HI:PORT_NUM_POS_LO]), PW'(1));
        chk("read_is_write", PW'(got[IS_WRITE_POS]), '0);

        // Partial write
        txn(0, mk_pkt(1'b1, 32'h100, ALL_AA, 16'hFFFF, 2'd0, 1'b0, 2'd0), lat, got);
        txn(0, mk_pkt(1'b1, 32'h100, ALL_55, 16'h000F, 2'd3, 1'b1, 2'd2), lat, got);
        chk("write_latency", PW'(lat), PW'(13));
        chk("write_is_write", PW'(got[IS_WRITE_POS]), PW'(1));
        chk("write_merged", PW'(got[DATA_POS_HI:DATA_POS_LO]), PW'(MERGED));
        chk("write_mask_echo", PW'(got[BYTE_MASK_POS_HI:BYTE_MASK_POS_LO]), PW'(16'h000F));

        // Back-pressure with a competing request held valid
        exp_bp = mk_pkt(1'b0, 32'h400, PAT_P, 16'hFFFF, 2'd2, 1'b1, 2'd1);
        issue(0, mk_pkt(1'b0, 32'h400, '0, 16'hFFFF, 2'd2, 1'b1, 2'd1), acc);
        for (int i = 0; i < 60 && !ret[0][VALID_POS]; i++) tick();
        req[0] = mk_pkt(1'b0, 32'h100, '0, 16'h0000, 2'd0, 1'b0, 2'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_hold", ret[0], exp_bp);
            chk("bp_no_ack", PW'(ack_out[0]), '0);
        end
        ack_in[0] = 1'b1; tick(); ack_in[0] = 1'b0;
        chk("bp_exit_ret", ret[0], '0);
        chk("bp_exit_no_ack", PW'(ack_out[0]), '0);
        tick();
        chk("bp_second_ack", PW'(ack_out[0]), PW'(1));
        acc = cyc;
        req[0] = '0;
        complete(0, 0, acc, lat, got);
        chk("bp_second_data", PW'(got[DATA_POS_HI:DATA_POS_LO]), PW'(MERGED));

        // Index wrap-around: block DEPTH+3 aliases block 3
        txn(0, mk_pkt(1'b1, 32'h0010_0030, PAT_W, 16'hFFFF, 2'd0, 1'b0, 2'd0), lat, got);
        txn(0, mk_pkt(1'b0, 32'h30, '0, 16'h0000, 2'd0, 1'b0, 2'd0), lat, got);
        chk("wrap_data", PW'(got[DATA_POS_HI:DATA_POS_LO]), PW'(PAT_W));

        // Reset during the delay phase of a write
        txn(0, mk_pkt(1'b1, 32'h200, PAT_Q, 16'hFFFF, 2'd0, 1'b0, 2'd0), lat, got);
        issue(0, mk_pkt(1'b1, 32'h200, PAT_Z, 16'hFFFF, 2'd1, 1'b0, 2'd0), acc);
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_ack", PW'(ack_out[0]), '0);
        chk("midrst_ret", ret[0], '0);
        chk("midrst_busy", PW'(busy[0]), '0);
        txn(0, mk_pkt(1'b0, 32'h200, '0, 16'h0000, 2'd0, 1'b0, 2'd0), lat, got);
        chk("midrst_storage", PW'(got[DATA_POS_HI:DATA_POS_LO]), PW'(PAT_Q));
        chk("midrst_read_latency", PW'(lat), PW'(12));

        // Zero-delay build: invalid packet ignored, mask-0 accesses
        req[1] = '1;
        req[1][VALID_POS] = 1'b0;
        repeat (4) tick();
        req[1] = '0;
        txn(1, mk_pkt(1'b1, 32'h50, PAT_R, 16'hFFFF, 2'd0, 1'b0, 2'd0), lat, got);
        chk("d0_write_latency", PW'(lat), PW'(3));
        txn(1, mk_pkt(1'b0, 32'h50, '0, 16'h0000, 2'd2, 1'b0, 2'd0), lat, got);
        chk("d0_read_latency", PW'(lat), PW'(2));
        chk("d0_read_data", PW'(got[DATA_POS_HI:DATA_POS_LO]), PW'(PAT_R));
        txn(1, mk_pkt(1'b1, 32'h50, PAT_X, 16'h0000, 2'd0, 1'b0, 2'd0), lat, got);
        chk("d0_mask0_ret", PW'(got[DATA_POS_HI:DATA_POS_LO]), PW'(PAT_R));
        txn(1, mk_pkt(1'b0, 32'h50, '0, 16'h0000, 2'd0, 1'b0, 2'd0), lat, got);
        chk("d0_mask0_storage", PW'(got[DATA_POS_HI:DATA_POS_LO]), PW'(PAT_R));
        txn(1, mk_pkt(1'b1, 32'h130, PAT_X, 16'hFFFF, 2'd0, 1'b0, 2'd0), lat, got);
        txn(1, mk_pkt(1'b0, 32'h30, '0, 16'h0000, 2'd0, 1'b0, 2'd0), lat, got);
        chk("d0_wrap_data", PW'(got[DATA_POS_HI:DATA_POS_LO]), PW'(PAT_X));

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got no end of stimulus, expected completion before 200000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
